// File: rtl/seg_disp.sv
//  +------------------------------------------------------------------------+
//  | Module   : seg_disp                                                    |
//  | Purpose  : Multi-digit seven-segment display driver. Latches a hex     |
//  |            value with per-digit decimal point and blink masks, decodes |
//  |            0-F, optionally blanks leading zeros, and drives registered |
//  |            active-low segment patterns for every digit.                |
//  | Ports    : clk, rst (async, active-high)                               |
//  |            i_load    - capture strobe for the i_* fields               |
//  |            i_value   - 4*DIGITS hex nibbles, digit 0 least significant |
//  |            i_dp      - decimal point enable per digit                  |
//  |            i_blink   - blink enable per digit                          |
//  |            i_lz_en   - leading-zero suppression enable                 |
//  |            o_seg     - 8*DIGITS active-low segments {a..g,dp}/digit    |
//  |            o_phase   - blink phase (1 = blinking digits dark)          |
//  |            o_an, o_scan_seg - multiplexed scan outputs, only present   |
//  |            when SEG_DISP_SCAN_EN is defined                            |
//  | Options  : `define SEG_DISP_SCAN_EN to add the scan outputs            |
//  | Revision : 1.0 - initial release                                       |
//  +------------------------------------------------------------------------+
`default_nettype none

module seg_disp #(
  parameter int DIGITS    = 8,
  parameter int BLINK_DIV = 24,
  parameter int SCAN_DIV  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_load,
  input  logic [4*DIGITS-1:0]   i_value,
  input  logic [DIGITS-1:0]     i_dp,
  input  logic [DIGITS-1:0]     i_blink,
  input  logic                  i_lz_en,
  output logic [8*DIGITS-1:0]   o_seg,
`ifdef SEG_DISP_SCAN_EN
  output logic [DIGITS-1:0]     o_an,
  output logic [7:0]            o_scan_seg,
`endif
  output logic                  o_phase
);

  logic [4*DIGITS-1:0]  r_value;
  logic [DIGITS-1:0]    r_dp;
  logic [DIGITS-1:0]    r_blink;
  logic                 r_lz;
  logic [BLINK_DIV-1:0] r_blink_cnt;
  logic [8*DIGITS-1:0]  w_seg_next;

  // Active-high pattern, bit7 = a .. bit1 = g, bit0 = dp (left clear here).
  function automatic logic [7:0] f_decode(input logic [3:0] nib);
    logic [7:0] pat;
    case (nib)
      4'h0: pat = 8'hFC;  4'h1: pat = 8'h60;  4'h2: pat = 8'hDA;  4'h3: pat = 8'hF2;
      4'h4: pat = 8'h66;  4'h5: pat = 8'hB6;  4'h6: pat = 8'hBE;  4'h7: pat = 8'hE0;
      4'h8: pat = 8'hFE;  4'h9: pat = 8'hF6;  4'hA: pat = 8'hEE;  4'hB: pat = 8'h3E;
      4'hC: pat = 8'h9C;  4'hD: pat = 8'h7A;  4'hE: pat = 8'h9E;  default: pat = 8'h8E;
    endcase
    return pat;
  endfunction

  // Capture registers and blink counter; a load restarts the blink period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_value     <= '0;
      r_dp        <= '0;
      r_blink     <= '0;
      r_lz        <= 1'b0;
      r_blink_cnt <= '0;
    end else begin
      if (i_load) begin
        r_value     <= i_value;
        r_dp        <= i_dp;
        r_blink     <= i_blink;
        r_lz        <= i_lz_en;
        r_blink_cnt <= '0;
      end else begin
        r_blink_cnt <= r_blink_cnt + 1'b1;
      end
    end
  end

  assign o_phase = r_blink_cnt[BLINK_DIV-1];

  // Next segment image. w_run stays high while every digit from the top
  // down to the current one is a blank zero; digit 0 is always shown.
  always_comb begin
    logic w_run;
    logic [7:0] w_pat;
    w_run      = r_lz;
    w_pat      = 8'h00;
    w_seg_next = '1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      w_run = w_run && (r_value[4*k +: 4] == 4'h0) && !r_dp[k];
      w_pat = f_decode(r_value[4*k +: 4]) | {7'b0, r_dp[k]};
      if (o_phase && r_blink[k]) begin
        w_seg_next[8*k +: 8] = 8'hFF;
      end else if (w_run && (k != 0)) begin
        w_seg_next[8*k +: 8] = 8'hFF;
      end else begin
        w_seg_next[8*k +: 8] = ~w_pat;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_seg <= '1;
    end else begin
      o_seg <= w_seg_next;
    end
  end

`ifdef SEG_DISP_SCAN_EN
  localparam int c_IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [SCAN_DIV-1:0] r_scan_cnt;
  logic [c_IDX_W-1:0]  r_idx;
  logic [c_IDX_W-1:0]  w_idx_next;

  // The index moves when the prescaler wraps; loads do not touch it.
  always_comb begin
    w_idx_next = r_idx;
    if (&r_scan_cnt) begin
      w_idx_next = (r_idx == c_IDX_W'(DIGITS - 1)) ? '0 : r_idx + 1'b1;
    end
  end

  // o_scan_seg is loaded with the slice the new index selects, so it
  // always matches the o_seg slice chosen by o_an in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scan_cnt <= '0;
      r_idx      <= '0;
      o_scan_seg <= 8'hFF;
    end else begin
      r_scan_cnt <= r_scan_cnt + 1'b1;
      r_idx      <= w_idx_next;
      o_scan_seg <= w_seg_next[8*w_idx_next +: 8];
    end
  end

  assign o_an = ~(DIGITS'(1) << r_idx);
`endif

endmodule

`default_nettype wire

// File: tb/tb_seg_disp.sv
//  +------------------------------------------------------------------------+
//  | Module   : tb_seg_disp                                                 |
//  | Purpose  : Self-checking bench for seg_disp (DIGITS=4, BLINK_DIV=4,    |
//  |            SCAN_DIV=2). A behavioural model tracks the expected        |
//  |            outputs; directed vectors add literal expectations.         |
//  | Revision : 1.0 - initial release                                       |
//  +------------------------------------------------------------------------+
`default_nettype none

module tb_seg_disp;
  localparam int D  = 4;
  localparam int BD = 4;
  localparam int SD = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           i_load;
  logic [4*D-1:0] i_value;
  logic [D-1:0]   i_dp;
  logic [D-1:0]   i_blink;
  logic           i_lz_en;
  logic [8*D-1:0] o_seg;
  logic           o_phase;
`ifdef SEG_DISP_SCAN_EN
  logic [D-1:0]   o_an;
  logic [7:0]     o_scan_seg;
`endif

  int checks = 0;
  int errors = 0;

  seg_disp #(.DIGITS(D), .BLINK_DIV(BD), .SCAN_DIV(SD)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_load     (i_load),
    .i_value    (i_value),
    .i_dp       (i_dp),
    .i_blink    (i_blink),
    .i_lz_en    (i_lz_en),
    .o_seg      (o_seg),
`ifdef SEG_DISP_SCAN_EN
    .o_an       (o_an),
    .o_scan_seg (o_scan_seg),
`endif
    .o_phase    (o_phase)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [7:0] pat [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                           8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};

  logic [4*D-1:0] m_value;
  logic [D-1:0]   m_dp, m_blink;
  logic           m_lz;
  int             m_cnt, m_scnt, m_idx;
  logic [8*D-1:0] exp_seg;
  logic           exp_phase;
  logic [7:0]     exp_scan;

  function automatic logic [8*D-1:0] model_seg(input logic [4*D-1:0] v, input logic [D-1:0] dp,
                                               input logic [D-1:0] bl, input logic lz, input logic ph);
    logic [8*D-1:0] r;
    int top;
    top = 0;
    for (int k = 0; k < D; k++) if (v[4*k +: 4] != 4'h0 || dp[k]) top = k;
    for (int k = 0; k < D; k++) begin
      if (ph && bl[k])        r[8*k +: 8] = 8'hFF;
      else if (lz && k > top) r[8*k +: 8] = 8'hFF;
      else                    r[8*k +: 8] = ~(pat[v[4*k +: 4]] | {7'b0, dp[k]});
    end
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_value = '0; m_dp = '0; m_blink = '0; m_lz = 1'b0;
      m_cnt = 0; m_scnt = 0; m_idx = 0;
      exp_seg = '1; exp_phase = 1'b0; exp_scan = 8'hFF;
    end else begin
      exp_seg = model_seg(m_value, m_dp, m_blink, m_lz, m_cnt >= (1 << (BD - 1)));
      if (i_load) begin
        m_value = i_value; m_dp = i_dp; m_blink = i_blink; m_lz = i_lz_en; m_cnt = 0;
      end else begin
        m_cnt = (m_cnt + 1) % (1 << BD);
      end
      exp_phase = (m_cnt >= (1 << (BD - 1)));
      if (m_scnt == (1 << SD) - 1) m_idx = (m_idx + 1) % D;
      m_scnt = (m_scnt + 1) % (1 << SD);
      exp_scan = exp_seg[8*m_idx +: 8];
    end
  end

  // Continuous comparison on every falling edge outside reset.
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (o_seg !== exp_seg) begin
        errors++;
        $display("FAIL seg_model t=%0t got=%h exp=%h", $time, o_seg, exp_seg);
      end
      checks++;
      if (o_phase !== exp_phase) begin
        errors++;
        $display("FAIL phase_model t=%0t got=%b exp=%b", $time, o_phase, exp_phase);
      end
`ifdef SEG_DISP_SCAN_EN
      checks++;
      if (o_an !== ~(D'(1) << m_idx)) begin
        errors++;
        $display("FAIL an_model t=%0t got=%b exp_idx=%0d", $time, o_an, m_idx);
      end
      checks++;
      if (o_scan_seg !== exp_scan) begin
        errors++;
        $display("FAIL scan_model t=%0t got=%h exp=%h", $time, o_scan_seg, exp_scan);
      end
`endif
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic check(input string name, input logic [8*D-1:0] got, input logic [8*D-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Called just after a falling edge; returns after the capture edge.
  task automatic do_load(input logic [4*D-1:0] v, input logic [D-1:0] dp,
                         input logic [D-1:0] bl, input logic lz);
    i_value = v; i_dp = dp; i_blink = bl; i_lz_en = lz; i_load = 1'b1;
    @(negedge clk);
    i_load = 1'b0;
  endtask

  initial begin
    rst = 1'b1; i_load = 1'b0; i_value = '0; i_dp = '0; i_blink = '0; i_lz_en = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_seg", o_seg, 32'hFFFFFFFF);
    check("reset_phase", {31'b0, o_phase}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    do_load(16'h1A2F, 4'b0000, 4'b0000, 1'b0);
    @(negedge clk);
    check("hex_1A2F", o_seg, 32'h9F112571);

    do_load(16'h0050, 4'b0000, 4'b0000, 1'b1);
    @(negedge clk);
    check("lz_0050", o_seg, 32'hFFFF4903);

    do_load(16'h0000, 4'b0000, 4'b0000, 1'b1);
    @(negedge clk);
    check("lz_0000", o_seg, 32'hFFFFFF03);

    do_load(16'h0007, 4'b0100, 4'b0000, 1'b1);
    @(negedge clk);
    check("lz_dp_0007", o_seg, 32'hFF02031F);

    do_load(16'h0003, 4'b0000, 4'b0001, 1'b0);
    @(negedge clk);
    check("blink_lit", o_seg, 32'h0303030D);
    repeat (8) @(negedge clk);
    check("blink_dark", o_seg, 32'h030303FF);
    check("blink_phase1", {31'b0, o_phase}, 32'h1);
    do_load(16'h0003, 4'b0000, 4'b0001, 1'b0);
    check("reload_phase0", {31'b0, o_phase}, 32'h0);
    @(negedge clk);
    check("reload_lit", o_seg, 32'h0303030D);

    repeat (20) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_seg", o_seg, 32'hFFFFFFFF);
    check("async_rst_phase", {31'b0, o_phase}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_zero", o_seg, 32'h03030303);

    do_load(16'hBCDE, 4'b1010, 4'b0110, 1'b1);
    repeat (40) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/seg_disp.md
Name: seg_disp

Overview:
Parametrised multi-digit seven-segment display driver; successor to the single-digit octal decoder.
- Latches a DIGITS-wide hex value with per-digit decimal point and blink masks on a load strobe.
- Decodes the full 0-F hex range and optionally suppresses leading zeros.
- Produces registered active-low segment patterns for every digit; sits between CPU/debug status logic and the board's segment pins.

Parameters:
DIGITS, 8, number of digits (1..8)
BLINK_DIV, 24, blink counter width; blink phase = counter MSB, period 2^BLINK_DIV cycles
SCAN_DIV, 16, scan counter width; used only with SEG_DISP_SCAN_EN

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
i_load  in  1  load strobe; captures i_value, i_dp, i_blink, i_lz_en
i_value  in  4*DIGITS  hex nibbles; digit k = bits [4k+3:4k]; digit 0 least significant
i_dp  in  DIGITS  decimal point enable per digit
i_blink  in  DIGITS  blink enable per digit
i_lz_en  in  1  leading-zero suppression enable
o_seg  out  8*DIGITS  active-low segments; digit k = bits [8k+7:8k]; bit7=a .. bit1=g, bit0=dp
o_phase  out  1  current blink phase (1 = blinking digits dark)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - value_q=0, dp_q=0, blink_q=0, lz_q=0.
  - Blink counter = 0; o_phase=0.
  - o_seg = all 8'hFF (all digits dark).
- Load: on a clk edge with i_load=1, all input fields are captured into *_q and the blink counter is cleared to 0.
  - o_seg reflects the new data on the following edge (1-cycle latency after capture).
  - No ready signal; a load is accepted every cycle it is asserted.
- Blink counter: free-running, BLINK_DIV bits, wraps 2^BLINK_DIV-1 -> 0; o_phase = counter MSB.
  - A load clears the counter; load wins over increment.
- Decode (active-high pattern, inverted onto o_seg):
  - 0 FC, 1 60, 2 DA, 3 F2, 4 66, 5 B6, 6 BE, 7 E0
  - 8 FE, 9 F6, A EE, b 3E, C 9C, d 7A, E 9E, F 8E
  - dp_q[k] sets pattern bit0.
- Leading-zero suppression, when lz_q=1:
  - Scan from digit DIGITS-1 downward. Digit k is dark (8'hFF) while it and every higher digit have nibble 0 and dp clear.
  - Digit 0 is never suppressed, so value 0 shows a single "0".
- Blink: when o_phase=1 and blink_q[k]=1, digit k is dark. Blink overrides decode and dp.
- o_seg is registered every cycle from the current *_q and phase; there are no combinational paths from inputs to outputs.
- Reset asserted mid-operation: everything returns to reset values immediately, without waiting for a clock edge. After release, the first edge resumes with the counter at 0.

Optional Feature:
SEG_DISP_SCAN_EN: when defined, adds multiplexed scan outputs.
- New ports:
  - o_an  out  DIGITS  active-low one-hot anode select
  - o_scan_seg  out  8  segment pattern of the selected digit
- SCAN_DIV-bit prescaler. On each wrap, the digit index advances 0,1,..,DIGITS-1,0.
- Reset state: index 0, o_an = ~1, o_scan_seg = 8'hFF.
- o_scan_seg is registered: the o_seg slice of the index selected by o_an in the same cycle.
- A load does not reset the scan index.
- When the macro is undefined, these ports and their counters are absent.

Test Plan:
- Reset check, DIGITS=4, BLINK_DIV=4: assert rst asynchronously between edges -> o_seg=32'hFFFFFFFF immediately, o_phase=0.
- Load i_value=16'h1A2F, dp=0, blink=0, lz=0 -> two edges later o_seg = {~60,~EE,~DA,~8E} = 32'h9F1125_71.
- Load i_value=16'h0050, lz=1 -> digits 3,2 = FF; digit1 = ~B6 = 49; digit0 = ~FC = 03. Load 16'h0000 with lz=1 -> only digit0 = 03.
- Load i_value=16'h0007 with i_dp=4'b0100, lz=1 -> digit2 = ~(FC|01) = 02 (dp stops suppression); digit3 = FF.
- Load with i_blink=4'b0001, BLINK_DIV=4 -> digit0 shows its value for 8 cycles, then FF for 8 cycles, repeating. A re-load mid-dark-phase clears phase to 0.
- With SEG_DISP_SCAN_EN, SCAN_DIV=2, DIGITS=4: o_an steps E,D,B,7,E every 4 cycles, and o_scan_seg matches the selected o_seg slice.
